multiplier_seq: RTL and testbench

MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

---
 rtl/multiplier_seq.sv | 187 ++++++++++++++++++
 tb/tb_multiplier_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_seq.sv
// -----------------------------------------------------------------------------
// multiplier_seq
// Sequential signed 32x32 multiplier. Operand magnitudes are multiplied with a
// radix-2 shift-add loop (one multiplier bit per clock, 32 iterations) into a
// 64-bit accumulator; the product sign is applied once the loop completes.
// A start pulse (mult) is honoured in every state and always restarts the
// computation from the operands present on that edge. Results are presented
// through registered outputs that read zero except in the DONE state.
// -----------------------------------------------------------------------------
module multiplier_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        mult,
    output logic [31:0] data_result,
    output logic        data_overflow,
    output logic        data_ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Unsigned magnitude of a two's-complement value. The most negative value
    // maps onto itself, which read as unsigned is exactly 2^31.
    function automatic logic [31:0] magnitude(input logic [31:0] value);
        logic [31:0] mag;
        if (value[31]) begin
            mag = ~value + 32'd1;
        end else begin
            mag = value;
        end
        return mag;
    endfunction

    // True when the signed product (magnitude prod, sign neg) does not fit in
    // 32-bit two's complement. Negative results may reach 2^31, positive ones
    // only 2^31-1.
    function automatic logic product_overflow(input logic [63:0] prod,
                                              input logic        neg);
        logic ovf;
        if (neg) begin
            ovf = (prod > 64'h0000_0000_8000_0000);
        end else begin
            ovf = (prod > 64'h0000_0000_7FFF_FFFF);
        end
        return ovf;
    endfunction

    // Two's-complement negation of the low product word; only the low 32 bits
    // of -P are ever presented, so the upper half never needs negating.
    function automatic logic [31:0] apply_sign(input logic [31:0] prod_low,
                                               input logic        neg);
        logic [31:0] res;
        if (neg) begin
            res = ~prod_low + 32'd1;
        end else begin
            res = prod_low;
        end
        return res;
    endfunction

    localparam logic [5:0] LAST_ITER  = 6'd31;
    localparam logic [5:0] ITER_LIMIT = 6'd32;

    state_t      state_r;
    state_t      state_next_s;

    logic [63:0] acc_r;        // running sum of partial products
    logic [63:0] mcand_r;      // multiplicand magnitude, shifted left per step
    logic [31:0] mplier_r;     // multiplier magnitude, shifted right per step
    logic [5:0]  count_r;      // completed iterations, saturates at 32
    logic        sign_r;       // sign of the final product

    logic        last_iter_s;
    logic [31:0] result_next_s;
    logic        overflow_next_s;

    logic [31:0] result_r;
    logic        overflow_r;
    logic        ready_r;

    assign last_iter_s = (count_r == LAST_ITER);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: a start pulse wins from any state; BUSY exits to DONE
    // on the edge that performs the 32nd iteration.
    always_comb begin
        state_next_s = state_r;
        if (mult) begin
            state_next_s = ST_BUSY;
        end else begin
            case (state_r)
                ST_IDLE: state_next_s = ST_IDLE;
                ST_BUSY: begin
                    if (last_iter_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_BUSY;
                    end
                end
                ST_DONE: state_next_s = ST_DONE;
                default: state_next_s = ST_IDLE;
            endcase
        end
    end

    // Shift-add datapath: load magnitudes on start, one iteration per BUSY edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc_r    <= 64'd0;
            mcand_r  <= 64'd0;
            mplier_r <= 32'd0;
            count_r  <= 6'd0;
            sign_r   <= 1'b0;
        end else if (mult) begin
            acc_r    <= 64'd0;
            mcand_r  <= {32'd0, magnitude(data_operandA)};
            mplier_r <= magnitude(data_operandB);
            count_r  <= 6'd0;
            sign_r   <= data_operandA[31] ^ data_operandB[31];
        end else if (state_r == ST_BUSY) begin
            if (mplier_r[0]) begin
                acc_r <= acc_r + mcand_r;
            end else begin
                acc_r <= acc_r;
            end
            mcand_r  <= {mcand_r[62:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[31:1]};
            if (count_r != ITER_LIMIT) begin
                count_r <= count_r + 6'd1;
            end else begin
                count_r <= count_r;
            end
        end else begin
            acc_r    <= acc_r;
            mcand_r  <= mcand_r;
            mplier_r <= mplier_r;
            count_r  <= count_r;
            sign_r   <= sign_r;
        end
    end

    // Signed result and overflow flag derived from the finished accumulator.
    always_comb begin
        result_next_s   = apply_sign(acc_r[31:0], sign_r);
        overflow_next_s = product_overflow(acc_r, sign_r);
    end

    // Output registers: load only while settled in DONE with no restart
    // pending, so a restart or reset never leaves a stale result flagged ready.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b0;
        end else if (mult) begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b0;
        end else if (state_r == ST_DONE) begin
            result_r   <= result_next_s;
            overflow_r <= overflow_next_s;
            ready_r    <= 1'b1;
        end else begin
            result_r   <= 32'd0;
            overflow_r <= 1'b0;
            ready_r    <= 1'b0;
        end
    end

    assign data_result   = result_r;
    assign data_overflow = overflow_r;
    assign data_ready    = ready_r;

endmodule

// File: tb/tb_multiplier_seq.sv
// -----------------------------------------------------------------------------
// tb_multiplier_seq
// Directed self-checking bench for multiplier_seq. Edge 0 is the rising edge
// on which mult is sampled high; outputs are sampled 1 time unit after edges.
// -----------------------------------------------------------------------------
module tb_multiplier_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        mult = 1'b0;
    logic [31:0] data_result;
    logic        data_overflow;
    logic        data_ready;

    int checks = 0;
    int fails  = 0;

    multiplier_seq dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .mult          (mult),
        .data_result   (data_result),
        .data_overflow (data_overflow),
        .data_ready    (data_ready)
    );

    always #5 clock = ~clock;

    // Drive a one-edge start pulse; returns 1 unit after edge 0 with operands
    // scrambled so that any late sampling would corrupt the result.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        mult = 1'b1;
        @(posedge clock);
        #1;
        mult = 1'b0;
        data_operandA = ~a;
        data_operandB = b ^ 32'h5A5A_5A5A;
    endtask

    // Full operation: ready low through edge 32, result valid at edge 33.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_ovf,
                          input string name);
        logic early;
        early = 1'b0;
        start_op(a, b);
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            if (data_ready !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            fails++;
            $display("FAIL %s_latency: data_ready rose before edge 33, required 0 through edge 32", name);
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_ready: got %b required 1", name, data_ready);
        end
        checks++;
        if (data_result !== exp_res) begin
            fails++;
            $display("FAIL %s_result: got %h required %h", name, data_result, exp_res);
        end
        checks++;
        if (data_overflow !== exp_ovf) begin
            fails++;
            $display("FAIL %s_overflow: got %b required %b", name, data_overflow, exp_ovf);
        end
    endtask

    // Outputs cleared during and after reset.
    task automatic test_reset();
        #1;
        checks++;
        if ({data_result, data_overflow, data_ready} !== 34'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h/%b/%b required 0/0/0", data_result, data_overflow, data_ready);
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({data_result, data_overflow, data_ready} !== 34'd0) begin
            fails++;
            $display("FAIL idle_outputs: got %h/%b/%b required 0/0/0", data_result, data_overflow, data_ready);
        end
    endtask

    // Sign handling and overflow boundaries.
    task automatic test_products();
        run_op(32'd7,          32'd6,          32'd42,         1'b0, "7x6");
        run_op(-32'sd5,        32'd3,          32'hFFFF_FFF1,  1'b0, "m5x3");
        run_op(32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, "minx1");
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "minxm1");
        run_op(32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, "2p16sq");
        run_op(32'd0,          32'h7FFF_FFFF,  32'd0,          1'b0, "zero");
        run_op(32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, "m1xm1");
        run_op(32'hFFFF_0000,  32'h0000_8000,  32'h8000_0000,  1'b0, "neg2p31");
        run_op(32'h0001_0000,  32'h0000_8000,  32'h8000_0000,  1'b1, "pos2p31");
        run_op(32'd46341,      32'd46341,      32'h8000_1219,  1'b1, "46341sq");
        run_op(32'h7FFF_FFFF,  32'd2,          32'hFFFF_FFFE,  1'b1, "maxx2");
    endtask

    // DONE holds with stable outputs until the next start.
    task automatic test_done_hold();
        logic unstable;
        unstable = 1'b0;
        run_op(32'd12, 32'hFFFF_FFFD, 32'hFFFF_FFDC, 1'b0, "hold_setup");
        for (int k = 0; k < 20; k++) begin
            @(posedge clock);
            #1;
            if (data_ready !== 1'b1 || data_result !== 32'hFFFF_FFDC || data_overflow !== 1'b0)
                unstable = 1'b1;
        end
        checks++;
        if (unstable) begin
            fails++;
            $display("FAIL done_hold: outputs changed in DONE, required %h/0/1 held", 32'hFFFF_FFDC);
        end
    endtask

    // Restart at edge 10 of a 3x3 run: 4x5 ready at edge 43, 9 never shown.
    task automatic test_restart();
        logic bad;
        bad = 1'b0;
        start_op(32'd3, 32'd3);
        for (int k = 1; k <= 42; k++) begin
            @(negedge clock);
            if (k == 10) begin
                data_operandA = 32'd4;
                data_operandB = 32'd5;
                mult = 1'b1;
            end
            @(posedge clock);
            #1;
            mult = 1'b0;
            if (data_ready !== 1'b0 || data_result === 32'd9) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL restart_early: ready or stale 9 seen before edge 43, required ready 0");
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_ready !== 1'b1 || data_result !== 32'd20) begin
            fails++;
            $display("FAIL restart_result: got ready %b result %0d required 1/20", data_ready, data_result);
        end
    endtask

    // mult held high for edges 0..2: computation runs from edge 2.
    task automatic test_back_to_back();
        logic bad;
        bad = 1'b0;
        @(negedge clock);
        data_operandA = 32'd1; data_operandB = 32'd1; mult = 1'b1;
        @(negedge clock);
        data_operandA = 32'd2; data_operandB = 32'd2;
        @(negedge clock);
        data_operandA = 32'd3; data_operandB = 32'd7;
        @(posedge clock);
        #1;
        mult = 1'b0;
        data_operandA = 32'd100;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clock);
            #1;
            if (data_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL held_mult_early: ready before 33 edges after last mult, required 0");
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_ready !== 1'b1 || data_result !== 32'd21) begin
            fails++;
            $display("FAIL held_mult_result: got ready %b result %0d required 1/21", data_ready, data_result);
        end
    endtask

    // Asynchronous reset from DONE and mid-BUSY; mult during reset ignored.
    task automatic test_reset_cases();
        logic bad;
        run_op(32'd7, 32'd6, 32'd42, 1'b0, "pre_reset");
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data_result, data_overflow, data_ready} !== 34'd0) begin
            fails++;
            $display("FAIL async_reset_done: got %h/%b/%b required 0/0/0", data_result, data_overflow, data_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;

        // Reset at edge 15 of a BUSY run.
        start_op(32'd9, 32'd9);
        repeat (14) @(posedge clock);
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({data_result, data_overflow, data_ready} !== 34'd0) begin
            fails++;
            $display("FAIL async_reset_busy: got %h/%b/%b required 0/0/0", data_result, data_overflow, data_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL reset_discard: ready rose after reset without a new mult, required 0");
        end
        run_op(32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b0, "post_reset");

        // mult sampled while reset is low must be ignored.
        @(negedge clock);
        reset_n = 1'b0;
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        mult = 1'b1;
        @(posedge clock);
        @(negedge clock);
        mult = 1'b0;
        reset_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_ready !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            fails++;
            $display("FAIL mult_in_reset: ready rose from mult sampled in reset, required 0");
        end
        run_op(32'hFFFF_FFF9, 32'hFFFF_FFF8, 32'd56, 1'b0, "first_after_release");
    endtask

    initial begin
        test_reset();
        test_products();
        test_done_hold();
        test_restart();
        test_back_to_back();
        test_reset_cases();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
